// File: rtl/interp_fetch_pkg.sv
// -----------------------------------------------------------------------------
// interp_fetch_pkg
//   Shared constants and types for the interpolator fetch stage:
//   sample/table widths, FSM state encoding, and the neighbour-index helpers
//   (wrap or clamp at the ends of the 64-entry coarse table).
// -----------------------------------------------------------------------------
package interp_fetch_pkg;

    localparam int DATA_W = 8;               // sample and table-entry width
    localparam int IDX_W  = 6;               // coarse-table index width
    localparam int FRAC_W = 2;               // fractional bits (DATA_W = IDX_W + FRAC_W)

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ISS1 = 3'd1,
        ST_ISS2 = 3'd2,
        ST_ISS3 = 3'd3,
        ST_CAPT = 3'd4,
        ST_HOLD = 3'd5
    } fetch_state_t;

    // idx-1: wraps 0 -> 63, or sticks at 0 when clamping.
    function automatic logic [IDX_W-1:0] idx_prev(input logic [IDX_W-1:0] idx,
                                                  input logic            clamp);
        if (clamp && (idx == '0)) begin
            return '0;
        end
        return idx - IDX_W'(1);
    endfunction

    // idx+1: wraps 63 -> 0, or sticks at 63 when clamping.
    function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx,
                                                  input logic            clamp);
        if (clamp && (idx == '1)) begin
            return '1;
        end
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/interp_sync_fifo.sv
// -----------------------------------------------------------------------------
// interp_sync_fifo
//   Single-clock FIFO buffering input samples ahead of the fetch FSM.
//   The occupancy count is a register; full/empty are decoded from it so the
//   upstream ready never depends on a same-cycle pop.
// Ports:
//   clk, rst   clock, synchronous active-high reset (flushes contents)
//   i_push     write i_din (ignored when full)
//   i_pop      drop head entry (ignored when empty)
//   i_din      write data
//   o_dout     head entry (valid while !o_empty)
//   o_full     count == DEPTH
//   o_empty    count == 0
// -----------------------------------------------------------------------------
module interp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rd_ptr];

    // Storage is not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            // Simultaneous push and pop leave the count unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/interp_fetch.sv
// -----------------------------------------------------------------------------
// interp_fetch
//   Fetch stage in front of the quadratic LUT interpolator. Samples x are
//   queued in a small FIFO; for each one the FSM reads table[idx-1], table[idx]
//   and table[idx+1] (idx = x[7:2]) from a single-port RAM with 1-cycle read
//   latency, then presents the three entries plus frac = x[1:0].
//
//   Handshakes: a transfer happens on a rising clk edge where valid && ready
//   are both 1. Once asserted, valid stays high and the payload stays constant
//   until that transfer; ready may change freely and does not depend on valid.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/in_ready/in_x          upstream sample stream
//   tbl_rd_en/tbl_addr/tbl_rdata    table RAM read port (data 1 cycle later)
//   out_valid/out_ready             downstream handshake
//   out_y1/out_y2/out_y3/out_frac   table[idx-1], table[idx], table[idx+1], x[1:0]
//   busy            FSM not idle or samples still queued
//   dbg_state       current FSM state (fetch_state_t encoding)
// -----------------------------------------------------------------------------
module interp_fetch
    import interp_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit CLAMP      = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    output logic              tbl_rd_en,
    output logic [IDX_W-1:0]  tbl_addr,
    input  logic [DATA_W-1:0] tbl_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y1,
    output logic [DATA_W-1:0] out_y2,
    output logic [DATA_W-1:0] out_y3,
    output logic [FRAC_W-1:0] out_frac,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    fetch_state_t      r_state;
    logic [DATA_W-1:0] r_x;
    logic              r_rd_en;
    logic [IDX_W-1:0]  r_addr;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_y1;
    logic [DATA_W-1:0] r_y2;
    logic [DATA_W-1:0] r_y3;
    logic [FRAC_W-1:0] r_frac;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DATA_W-1:0] w_head;
    logic              w_push;
    logic              w_pop;
    logic [IDX_W-1:0]  w_head_idx;
    logic [IDX_W-1:0]  w_x_idx;
    logic [IDX_W-1:0]  w_i1_head;
    logic [IDX_W-1:0]  w_i2;
    logic [IDX_W-1:0]  w_i3;

    interp_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (in_x),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Ready comes from the registered count only: a full FIFO refuses even if
    // the FSM pops in the same cycle.
    assign in_ready = !w_fifo_full;
    assign w_push   = in_valid && !w_fifo_full;

    // A new sample starts either from IDLE or straight out of HOLD on the
    // accepting edge, which gives the 5-cycle back-to-back cadence.
    assign w_pop = !w_fifo_empty &&
                   ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready));

    // idx-1 is needed on the pop edge, before x is in r_x, so it is taken
    // from the FIFO head; idx and idx+1 come from the captured sample.
    assign w_head_idx = w_head[DATA_W-1:FRAC_W];
    assign w_x_idx    = r_x[DATA_W-1:FRAC_W];
    assign w_i1_head  = idx_prev(w_head_idx, CLAMP);
    assign w_i2       = w_x_idx;
    assign w_i3       = idx_next(w_x_idx, CLAMP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_rd_en     <= 1'b0;
            r_addr      <= '0;
            r_out_valid <= 1'b0;
            r_y1        <= '0;
            r_y2        <= '0;
            r_y3        <= '0;
            r_frac      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Start handled by the pop block below.
                end
                ST_ISS1: begin
                    r_addr  <= w_i2;
                    r_state <= ST_ISS2;
                end
                ST_ISS2: begin
                    r_y1    <= tbl_rdata;          // data for idx-1
                    r_addr  <= w_i3;
                    r_state <= ST_ISS3;
                end
                ST_ISS3: begin
                    r_y2    <= tbl_rdata;          // data for idx
                    r_rd_en <= 1'b0;               // address is left as is
                    r_state <= ST_CAPT;
                end
                ST_CAPT: begin
                    r_y3        <= tbl_rdata;      // data for idx+1
                    r_frac      <= r_x[FRAC_W-1:0];
                    r_out_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Outputs frozen and no reads until the triple is taken.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_fifo_empty) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // w_pop is only ever true in IDLE or in an accepting HOLD cycle.
            if (w_pop) begin
                r_x     <= w_head;
                r_rd_en <= 1'b1;
                r_addr  <= w_i1_head;
                r_state <= ST_ISS1;
            end
        end
    end

    assign tbl_rd_en = r_rd_en;
    assign tbl_addr  = r_addr;
    assign out_valid = r_out_valid;
    assign out_y1    = r_y1;
    assign out_y2    = r_y2;
    assign out_y3    = r_y3;
    assign out_frac  = r_frac;
    assign busy      = (r_state != ST_IDLE) || !w_fifo_empty;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_interp_fetch.sv
module tb_interp_fetch;
  import interp_fetch_pkg::*;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in_x = 8'h00;
  logic out_ready = 1'b0;

  logic in_ready, tbl_rd_en, out_valid, busy;
  logic [5:0] tbl_addr;
  logic [7:0] tbl_rdata = 8'h00;
  logic [7:0] out_y1, out_y2, out_y3;
  logic [1:0] out_frac;
  logic [2:0] dbg_state;

  logic in_ready_c, tbl_rd_en_c, out_valid_c, busy_c;
  logic [5:0] tbl_addr_c;
  logic [7:0] tbl_rdata_c = 8'h00;
  logic [7:0] out_y1_c, out_y2_c, out_y3_c;
  logic [1:0] out_frac_c;
  logic [2:0] dbg_state_c;

  int checks = 0;
  int errors = 0;

  logic [25:0] exp_q[$];
  logic [25:0] exp_qc[$];
  logic [25:0] sb_e;

  always #5 clk = ~clk;

  interp_fetch #(.FIFO_DEPTH(4), .CLAMP(1'b0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .tbl_rd_en(tbl_rd_en), .tbl_addr(tbl_addr), .tbl_rdata(tbl_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_y1(out_y1), .out_y2(out_y2),
    .out_y3(out_y3), .out_frac(out_frac), .busy(busy), .dbg_state(dbg_state)
  );

  interp_fetch #(.FIFO_DEPTH(4), .CLAMP(1'b1)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c), .in_x(in_x),
    .tbl_rd_en(tbl_rd_en_c), .tbl_addr(tbl_addr_c), .tbl_rdata(tbl_rdata_c),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_y1(out_y1_c), .out_y2(out_y2_c),
    .out_y3(out_y3_c), .out_frac(out_frac_c), .busy(busy_c), .dbg_state(dbg_state_c)
  );

  // ---------------- reference models ----------------
  function automatic logic [7:0] tbl_val(input int i);
    return 8'((3 * i) % 256);
  endfunction

  function automatic int model_idx(input int idx, input int d, input bit clamp);
    int v;
    v = idx + d;
    if (clamp) begin
      if (v < 0) v = 0;
      if (v > 63) v = 63;
    end else begin
      v = (v + 64) % 64;
    end
    return v;
  endfunction

  function automatic logic [25:0] model_triple(input logic [7:0] x, input bit clamp);
    int idx;
    idx = int'(x[7:2]);
    return {tbl_val(model_idx(idx, -1, clamp)), tbl_val(model_idx(idx, 0, clamp)),
            tbl_val(model_idx(idx, 1, clamp)), x[1:0]};
  endfunction

  // Synchronous table RAMs, 1-cycle read latency.
  always @(posedge clk) begin
    if (tbl_rd_en) tbl_rdata <= tbl_val(int'(tbl_addr));
    if (tbl_rd_en_c) tbl_rdata_c <= tbl_val(int'(tbl_addr_c));
  end

  // ---------------- scoreboard (sampled mid-cycle) ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model_triple(in_x, 1'b0));
        exp_qc.push_back(model_triple(in_x, 1'b1));
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_wrap: unexpected output %h, nothing expected", {out_y1, out_y2, out_y3, out_frac});
        end else begin
          sb_e = exp_q.pop_front();
          if ({out_y1, out_y2, out_y3, out_frac} !== sb_e) begin
            errors++;
            $display("FAIL sb_wrap: got %h expected %h", {out_y1, out_y2, out_y3, out_frac}, sb_e);
          end
        end
      end
      if (out_valid_c && out_ready) begin
        checks++;
        if (exp_qc.size() == 0) begin
          errors++;
          $display("FAIL sb_clamp: unexpected output %h, nothing expected", {out_y1_c, out_y2_c, out_y3_c, out_frac_c});
        end else begin
          sb_e = exp_qc.pop_front();
          if ({out_y1_c, out_y2_c, out_y3_c, out_frac_c} !== sb_e) begin
            errors++;
            $display("FAIL sb_clamp: got %h expected %h", {out_y1_c, out_y2_c, out_y3_c, out_frac_c}, sb_e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input string name);
    for (int k = 0; k < 20 && !out_valid; k++) tick();
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%b expected 1 within 20 cycles", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({in_ready, out_valid, tbl_rd_en, busy, tbl_addr, out_y1, out_y2, out_y3, out_frac} !== 36'h800000000) begin
      errors++;
      $display("FAIL reset_wrap: got %h expected 800000000",
               {in_ready, out_valid, tbl_rd_en, busy, tbl_addr, out_y1, out_y2, out_y3, out_frac});
    end
    checks++;
    if ({in_ready_c, out_valid_c, tbl_rd_en_c, busy_c, tbl_addr_c, out_y1_c, out_y2_c, out_y3_c, out_frac_c} !== 36'h800000000) begin
      errors++;
      $display("FAIL reset_clamp: got %h expected 800000000",
               {in_ready_c, out_valid_c, tbl_rd_en_c, busy_c, tbl_addr_c, out_y1_c, out_y2_c, out_y3_c, out_frac_c});
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
  endtask

  // One isolated sample: exact address sequence, latency and payload.
  task automatic test_single(input logic [7:0] x,
                             input logic [5:0] a1, input logic [5:0] a2, input logic [5:0] a3,
                             input logic [5:0] c1, input logic [5:0] c2, input logic [5:0] c3,
                             input logic [7:0] y1, input logic [7:0] y2, input logic [7:0] y3,
                             input logic [1:0] fr);
    logic [5:0] ea [3];
    logic [5:0] ec [3];
    ea[0] = a1; ea[1] = a2; ea[2] = a3;
    ec[0] = c1; ec[1] = c2; ec[2] = c3;
    out_ready = 1'b1; in_x = x; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({busy, tbl_rd_en, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL single_queued x=%h: busy,rd_en,out_valid=%b expected 100", x, {busy, tbl_rd_en, out_valid});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({tbl_rd_en, tbl_addr, tbl_rd_en_c, tbl_addr_c} !== {1'b1, ea[k], 1'b1, ec[k]}) begin
        errors++;
        $display("FAIL single_addr x=%h step %0d: rd/addr wrap=%b/%0d clamp=%b/%0d expected 1/%0d 1/%0d",
                 x, k, tbl_rd_en, tbl_addr, tbl_rd_en_c, tbl_addr_c, ea[k], ec[k]);
      end
    end
    tick();
    checks++;
    if ({tbl_rd_en, out_valid, tbl_addr} !== {1'b0, 1'b0, ea[2]}) begin
      errors++;
      $display("FAIL single_capt x=%h: rd_en=%b out_valid=%b addr=%0d expected 0 0 %0d",
               x, tbl_rd_en, out_valid, tbl_addr, ea[2]);
    end
    tick();
    checks++;
    if ({out_valid, out_y1, out_y2, out_y3, out_frac} !== {1'b1, y1, y2, y3, fr}) begin
      errors++;
      $display("FAIL single_out x=%h: valid=%b y=%0d,%0d,%0d frac=%0d expected 1 y=%0d,%0d,%0d frac=%0d",
               x, out_valid, out_y1, out_y2, out_y3, out_frac, y1, y2, y3, fr);
    end
    tick();
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_done x=%h: out_valid,busy=%b expected 00", x, {out_valid, busy});
    end
  endtask

  task automatic test_basic();
    test_single(8'h16, 6'd4, 6'd5, 6'd6, 6'd4, 6'd5, 6'd6, 8'd12, 8'd15, 8'd18, 2'd2);
  endtask

  task automatic test_edges();
    test_single(8'h00, 6'd63, 6'd0, 6'd1, 6'd0, 6'd0, 6'd1, 8'd189, 8'd0, 8'd3, 2'd0);
    test_single(8'hFF, 6'd62, 6'd63, 6'd0, 6'd62, 6'd63, 6'd63, 8'd186, 8'd189, 8'd0, 2'd3);
  endtask

  task automatic test_back_to_back();
    int acc;
    int hs;
    int last;
    logic [25:0] snap;
    acc = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_x = 8'($urandom_range(0, 255));
      in_valid = 1'b1;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (acc !== 5) begin
      errors++;
      $display("FAIL bp_accepted: got %0d expected 5", acc);
    end
    checks++;
    if ({in_ready, in_ready_c} !== 2'b00) begin
      errors++;
      $display("FAIL bp_in_ready: got %b expected 00", {in_ready, in_ready_c});
    end
    wait_out_valid("bp");
    snap = {out_y1, out_y2, out_y3, out_frac};
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if ({out_valid, tbl_rd_en, out_y1, out_y2, out_y3, out_frac} !== {1'b1, 1'b0, snap}) begin
        errors++;
        $display("FAIL bp_stable cycle %0d: valid=%b rd_en=%b data=%h expected 1 0 %h",
                 k, out_valid, tbl_rd_en, {out_y1, out_y2, out_y3, out_frac}, snap);
      end
    end
    out_ready = 1'b1;
    hs = 0;
    last = 0;
    for (int k = 0; k < 40 && hs < 5; k++) begin
      if (out_valid) begin
        if (hs > 0) begin
          checks++;
          if (k - last !== 5) begin
            errors++;
            $display("FAIL bp_spacing: gap %0d expected 5", k - last);
          end
        end
        last = k;
        hs++;
      end
      tick();
    end
    checks++;
    if (hs !== 5) begin
      errors++;
      $display("FAIL bp_count: got %0d outputs expected 5", hs);
    end
    checks++;
    if ({busy, exp_q.size() == 0} !== 2'b01) begin
      errors++;
      $display("FAIL bp_drained: busy=%b pending=%0d expected 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_push_pop_same_cycle();
    out_ready = 1'b0;
    in_x = 8'($urandom_range(0, 255)); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out_valid("pp");
    for (int k = 0; k < 3; k++) begin
      in_x = 8'($urandom_range(0, 255)); in_valid = 1'b1;
      tick();
    end
    // count = 3: push and pop on the same edge
    in_x = 8'($urandom_range(0, 255)); in_valid = 1'b1; out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pp_ready_at3: got %b expected 1", in_ready);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pp_ready_after: got %b expected 1", in_ready);
    end
    in_x = 8'($urandom_range(0, 255));
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL pp_full: in_ready got %b expected 0 (count should be 4)", in_ready);
    end
    // count = 4: pop edge with in_valid high must not accept
    wait_out_valid("pp_full");
    in_x = 8'hA5; in_valid = 1'b1; out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL pp_full_pop: in_ready got %b expected 0", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pp_after_pop: in_ready got %b expected 1", in_ready);
    end
    for (int k = 0; k < 60 && busy; k++) tick();
    checks++;
    if ({busy, exp_q.size() == 0, exp_qc.size() == 0} !== 3'b011) begin
      errors++;
      $display("FAIL pp_drain: busy=%b pending=%0d/%0d expected 0 0/0", busy, exp_q.size(), exp_qc.size());
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    out_ready = 1'b0;
    in_x = 8'($urandom_range(0, 255)); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out_valid("rm");
    for (int k = 0; k < 3; k++) begin
      in_x = 8'($urandom_range(0, 255)); in_valid = 1'b1;
      tick();
    end
    in_x = 8'($urandom_range(0, 255)); out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    checks++;
    if ({dbg_state, in_ready} !== {ST_ISS2, 1'b1}) begin
      errors++;
      $display("FAIL rm_setup: state=%0d in_ready=%b expected %0d 1", dbg_state, in_ready, ST_ISS2);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({in_ready, out_valid, tbl_rd_en, busy, tbl_addr, out_y1, out_y2, out_y3, out_frac} !== 36'h800000000) begin
      errors++;
      $display("FAIL rm_reset_wrap: got %h expected 800000000",
               {in_ready, out_valid, tbl_rd_en, busy, tbl_addr, out_y1, out_y2, out_y3, out_frac});
    end
    checks++;
    if ({in_ready_c, out_valid_c, tbl_rd_en_c, busy_c, tbl_addr_c, out_y1_c, out_y2_c, out_y3_c, out_frac_c} !== 36'h800000000) begin
      errors++;
      $display("FAIL rm_reset_clamp: got %h expected 800000000",
               {in_ready_c, out_valid_c, tbl_rd_en_c, busy_c, tbl_addr_c, out_y1_c, out_y2_c, out_y3_c, out_frac_c});
    end
    exp_q.delete();
    exp_qc.delete();
    rst = 1'b0; out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid || out_valid_c || tbl_rd_en || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rm_flushed: activity in %0d cycles after reset expected 0", seen);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_back_to_back();
    test_push_pop_same_cycle();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
